// File: rtl/sel_arbiter_2.sv
// Two-requester round-robin arbiter that drives the 2-to-1 selector and holds grants for bursts.
// Define SEL_ARBITER_STATS_EN to add the saturating grant counters grants_a / grants_b.
module sel_arbiter_2 #(
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_a,
    input  logic [WIDTH-1:0] data_a,
    input  logic             valid_b,
    input  logic [WIDTH-1:0] data_b,
    output logic             ready_a,
    output logic             ready_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             sel,
    output logic             busy
`ifdef SEL_ARBITER_STATS_EN
    ,
    output logic [15:0]      grants_a,
    output logic [15:0]      grants_b
`endif
);

    // state   | meaning
    // IDLE    | no grant held, sel keeps the last winner
    // GRANT_A | source A owns the bus
    // GRANT_B | source B owns the bus
    typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;

    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);

    state_t        state, state_n;
    logic [CW-1:0] beat_cnt, cnt_n;
    logic          last_a, last_a_n;
    logic          enter_a, enter_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            beat_cnt <= '0;
            last_a   <= 1'b0;
        end else begin
            state    <= state_n;
            beat_cnt <= cnt_n;
            last_a   <= last_a_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = beat_cnt;
        last_a_n  = last_a;
        enter_a   = 1'b0;
        enter_b   = 1'b0;
        ready_a   = 1'b0;
        ready_b   = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                if (valid_a && valid_b) begin
                    enter_a = !last_a;
                    enter_b = last_a;
                end else begin
                    enter_a = valid_a;
                    enter_b = valid_b;
                end
            end
            GRANT_A: begin
                busy      = 1'b1;
                out_valid = valid_a;
                ready_a   = out_ready;
                if (!valid_a || (out_ready && beat_cnt == LAST)) begin
                    // handover first, re-grant only when the burst ended with A still pending
                    if (valid_b)      enter_b = 1'b1;
                    else if (valid_a) enter_a = 1'b1;
                    else              state_n = IDLE;
                end else if (out_ready) begin
                    cnt_n = beat_cnt + 1'b1;
                end
            end
            GRANT_B: begin
                busy      = 1'b1;
                out_valid = valid_b;
                ready_b   = out_ready;
                if (!valid_b || (out_ready && beat_cnt == LAST)) begin
                    if (valid_a)      enter_a = 1'b1;
                    else if (valid_b) enter_b = 1'b1;
                    else              state_n = IDLE;
                end else if (out_ready) begin
                    cnt_n = beat_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (enter_a) begin
            state_n  = GRANT_A;
            cnt_n    = '0;
            last_a_n = 1'b1;
        end
        if (enter_b) begin
            state_n  = GRANT_B;
            cnt_n    = '0;
            last_a_n = 1'b0;
        end
    end

    // last_a doubles as the selector control: it tracks the current or most recent winner
    assign sel      = last_a;
    assign out_data = sel ? data_a : data_b;

`ifdef SEL_ARBITER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grants_a <= '0;
            grants_b <= '0;
        end else begin
            if (enter_a && grants_a != 16'hFFFF) grants_a <= grants_a + 16'd1;
            if (enter_b && grants_b != 16'hFFFF) grants_b <= grants_b + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sel_arbiter_2.sv
// Directed bench for sel_arbiter_2 (WIDTH=32, MAX_BURST=4); checks grant order, stalls and reset.
module tb_sel_arbiter_2;

    logic        clk;
    logic        rst;
    logic        valid_a, valid_b;
    logic [31:0] data_a, data_b;
    logic        ready_a, ready_b;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic        sel, busy;
`ifdef SEL_ARBITER_STATS_EN
    logic [15:0] grants_a, grants_b;
`endif

    int tests = 0;
    int fails = 0;

    sel_arbiter_2 #(.WIDTH(32), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_a   (valid_a),
        .data_a    (data_a),
        .valid_b   (valid_b),
        .data_b    (data_b),
        .ready_a   (ready_a),
        .ready_b   (ready_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sel       (sel),
        .busy      (busy)
`ifdef SEL_ARBITER_STATS_EN
        ,
        .grants_a  (grants_a),
        .grants_b  (grants_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; valid_a = 1'b0; valid_b = 1'b0;
        data_a = '0; data_b = '0; out_ready = 1'b0;
        #1;
        chk("rst_sel",       32'(sel), 0);
        chk("rst_busy",      32'(busy), 0);
        chk("rst_ready_a",   32'(ready_a), 0);
        chk("rst_ready_b",   32'(ready_b), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_beat_cnt",  32'(dut.beat_cnt), 0);
        step(); step();
        rst = 1'b0;

        // tie: 4 beats A, 4 beats B, alternating with no bubble
        data_a = 32'hAAAA_0001; data_b = 32'hBBBB_0001;
        valid_a = 1'b1; valid_b = 1'b1; out_ready = 1'b1;
        #1;
        chk("tie_idle_out_valid", 32'(out_valid), 0);
        chk("tie_idle_busy", 32'(busy), 0);
        step();
        for (int k = 0; k < 16; k++) begin
            automatic logic ea = ((k / 4) % 2) == 0;
            #1;
            chk("tie_sel", 32'(sel), 32'(ea));
            chk("tie_ready_a", 32'(ready_a), 32'(ea));
            chk("tie_ready_b", 32'(ready_b), 32'(!ea));
            chk("tie_out_data", out_data, ea ? 32'hAAAA_0001 : 32'hBBBB_0001);
            chk("tie_busy", 32'(busy), 1);
            step();
        end
        valid_a = 1'b0; valid_b = 1'b0;
        #1;
        chk("drop_out_valid", 32'(out_valid), 0);
        chk("drop_busy_held", 32'(busy), 1);
        step();
        chk("drop_idle_busy", 32'(busy), 0);
        chk("idle_sel_holds", 32'(sel), 1);

        // single requester, three beats then idle
        valid_a = 1'b1; data_a = 32'h11;
        step();
        chk("single_ready_a", 32'(ready_a), 1);
        chk("single_data_11", out_data, 32'h11);
        step(); data_a = 32'h22; #1;
        chk("single_data_22", out_data, 32'h22);
        chk("single_ready_a2", 32'(ready_a), 1);
        step(); data_a = 32'h33; #1;
        chk("single_data_33", out_data, 32'h33);
        step(); valid_a = 1'b0; #1;
        chk("single_out_valid_drop", 32'(out_valid), 0);
        step();
        chk("single_idle_busy", 32'(busy), 0);

        // back-pressure after first beat, then burst end hands over to B
        valid_a = 1'b1; data_a = 32'h11; out_ready = 1'b1;
        step();
        step();
        data_a = 32'h22; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_ready_a", 32'(ready_a), 0);
            chk("bp_out_data", out_data, 32'h22);
            chk("bp_out_valid", 32'(out_valid), 1);
            chk("bp_sel", 32'(sel), 1);
            chk("bp_beat_cnt", 32'(dut.beat_cnt), 1);
            step();
        end
        out_ready = 1'b1; valid_b = 1'b1; data_b = 32'hBB;
        step(); step();
        chk("bp_cnt_last", 32'(dut.beat_cnt), 3);
        chk("bp_still_a", 32'(sel), 1);
        step();
        chk("handover_sel", 32'(sel), 0);
        chk("handover_ready_b", 32'(ready_b), 1);
        chk("handover_data", out_data, 32'hBB);
        chk("handover_cnt", 32'(dut.beat_cnt), 0);

        // reset during beat 2 of a B burst
        valid_a = 1'b0;
        step();
        chk("midb_ready_b", 32'(ready_b), 1);
        rst = 1'b1;
        #1;
        chk("midb_rst_ready_b", 32'(ready_b), 0);
        chk("midb_rst_busy", 32'(busy), 0);
        chk("midb_rst_out_valid", 32'(out_valid), 0);
        valid_a = 1'b1; valid_b = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_idle", 32'(busy), 0);
        step();
        chk("post_rst_tie_sel", 32'(sel), 1);
        chk("post_rst_tie_ready_a", 32'(ready_a), 1);
        chk("post_rst_tie_ready_b", 32'(ready_b), 0);

        // reset during an A burst must still give A the next tie
        rst = 1'b1; #1; rst = 1'b0;
        step();
        chk("rst_in_a_tie_sel", 32'(sel), 1);
        chk("rst_in_a_ready_a", 32'(ready_a), 1);

        // ten alternating grants from a clean reset
        rst = 1'b1; #1; rst = 1'b0;
        step();
        repeat (37) step();
        chk("ten_grants_sel", 32'(sel), 0);
        chk("ten_grants_ready_b", 32'(ready_b), 1);
`ifdef SEL_ARBITER_STATS_EN
        chk("grants_a", 32'(grants_a), 5);
        chk("grants_b", 32'(grants_b), 5);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
